// File: rtl/result_display_pkg.sv
// Shared constants for the board result display: segment codes, digit count, scan states.
// No logic; latency n/a.
// No flow control; constants only.
package result_display_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment codes, bit6=g ... bit0=a.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment (gfedcba) decode.
// Latency: combinational, zero cycles.
// No flow control; output follows input continuously.
module hex_to_seg7
    import result_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// 4-deep result history shown on a multiplexed common-anode display, newest on digit 0.
// Latency: pins are registered, one cycle after state/index/history.
// No backpressure: samples arriving while frozen or cleared are dropped.
module result_display
    import result_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] out_in,
    input  logic       sample_en,
    input  logic       freeze,
    input  logic       clear,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] valid_count
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       VC_MAX     = 3'(NUM_DIGITS);

    logic [3:0]       hist [NUM_DIGITS];
    logic [2:0]       vc_q;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_t      state_q, state_d;
    logic [6:0]       dig_seg;
    logic             lit;

    // hist[0] is always the newest result; clear outranks a same-cycle sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
            vc_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
            vc_q <= '0;
        end else if (sample_en && !freeze) begin
            hist[0] <= out_in;
            for (int i = 1; i < NUM_DIGITS; i++) hist[i] <= hist[i-1];
            if (vc_q != VC_MAX) vc_q <= vc_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        case (state_q)
            SCAN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    state_d = BLANK;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            BLANK: begin
                idx_d   = idx_q + 2'd1;
                state_d = SCAN;
            end
        endcase
    end

    hex_to_seg7 u_dec (
        .hex (hist[idx_q]),
        .seg (dig_seg)
    );

    // Digits beyond the number of captured results stay dark.
    assign lit = (state_q == SCAN) && ({1'b0, idx_q} < vc_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (lit) begin
            an  <= ~(4'b0001 << idx_q);
            seg <= dig_seg;
            dp  <= (idx_q != 2'd0);
        end else begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end
    end

    assign valid_count = vc_q;

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream consumer of the single-cycle core's 4-bit result nibble (ALU result bits [3:0]) on the FPGA board.
- Captures the nibble whenever the core advances one instruction and keeps a 4-deep history of the most recent results.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display with newest-on-right ordering, a blanking slot between digits to prevent ghosting, and freeze/clear controls.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit is lit; legal range 2..2^20.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; the core and this block share this one clock.
- reset  input  1  asynchronous, active-high reset.
- out_in  input  4  result nibble from the core.
- sample_en  input  1  one-cycle strobe: out_in is valid and must be captured this cycle.
- freeze  input  1  level; while high, samples are ignored and the history is held.
- clear  input  1  synchronous one-cycle pulse; empties the history.
- an  output  4  digit anodes, active-low, one-hot-low when a digit is lit.
- seg  output  7  segments, active-low, bit6=g ... bit0=a.
- dp  output  1  decimal point, active-low; lit only on digit 0 (newest).
- valid_count  output  3  number of valid history entries, 0..4.

Behaviour:
- Reset values (asynchronous):
  - an=4'b1111, seg=7'h7F, dp=1, valid_count=0.
  - hist[0..3]=0, digit index=0, prescaler=0, state=SCAN.
- History:
  - On sample_en=1, freeze=0, clear=0: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=out_in.
  - valid_count increments and saturates at 4.
- Clear:
  - clear=1 sets valid_count<=0 and hist<=0.
  - clear has priority over sample_en in the same cycle; that sample is dropped.
- Freeze:
  - sample_en is ignored while freeze=1.
  - clear still acts while frozen.
  - Scanning continues while frozen.
- Scan FSM, two states:
  - SCAN: prescaler increments each cycle. When prescaler==SCAN_DIV-1: prescaler<=0, go to BLANK.
  - BLANK: exactly 1 cycle. Digit index <= index+1 (mod 4, 3 wraps to 0), then back to SCAN.
  - Digit period is SCAN_DIV+1 cycles; full frame is 4*(SCAN_DIV+1) cycles.
- Output generation (registered, 1-cycle latency from state/index/history to pins):
  - State BLANK, or index >= valid_count: an=1111, seg=7F, dp=1.
  - Otherwise: an = ~(1<<index), seg = decode(hist[index]), dp = (index==0) ? 0 : 1.
- History changes mid-digit appear on the next cycle's registered output. No frame tearing protection is required.
- Decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset asserted mid-operation: all state returns to reset values immediately. After release, scanning restarts at digit 0 in SCAN with prescaler=0.
- Arithmetic:
  - Prescaler is unsigned CNT_W bits; the compare is equality only.
  - Digit index is 2 bits with natural wrap.
  - valid_count is 3 bits, clamped to 4.

Decomposition:
- Shared package:
  - SEG_BLANK=7'h7F and the 16 hex segment codes as named localparams.
  - FSM state encoding: SCAN=1'b0, BLANK=1'b1.
  - NUM_DIGITS=4.
- One sub-module, hex_to_seg7: purely combinational 4-bit -> 7-bit active-low decode, reusable by other board-level blocks.
- History, prescaler, FSM and output registers live in result_display itself.

Test Plan (SCAN_DIV=4 for all scenarios):
- Reset release, no samples -> an=1111, seg=7F, dp=1, valid_count=0 for a full frame (20 cycles).
- Samples 3, A, 0, F, one strobe each, freeze=0 -> valid_count=4. Per frame:
  - digit0: an=1110, seg=0E, dp=0.
  - digit1: an=1101, seg=40.
  - digit2: an=1011, seg=08.
  - digit3: an=0111, seg=30.
  - Each digit is lit 4 cycles, followed by 1 blank cycle with an=1111.
- Single sample 5 -> valid_count=1. digit0 shows seg=12, dp=0; digits 1-3 keep an=1111. A 5th..9th sample saturates valid_count at 4 and the oldest value is discarded.
- clear and sample_en=1 (out_in=7) in the same cycle -> valid_count=0 next cycle and the display is fully blank. The next lone sample 7 gives digit0 seg=78.
- freeze=1 with sample_en strobes of 9 -> history and valid_count unchanged and the display is unchanged. After freeze=0, the next strobe captures.
- Reset pulsed while digit 2 is lit -> an=1111, seg=7F the same cycle (asynchronous). After release, valid_count=0 and the first lit slot is digit 0 at prescaler 0.
